// File: rtl/uart_rx_param.sv
// uart_rx_param -- oversampling UART receiver with one-word output buffer.
//
// Ports:
//   clk, rst     system clock (rising edge), synchronous active-high reset
//   rxd          asynchronous serial line, idle high
//   baud_div     clocks per baud tick minus 1
//   data_out     received word (LSB was sent first)
//   data_valid   data_out holds a word not yet taken by the consumer
//   data_ready   consumer accepts the word in data_out
//   frame_err    a stop bit of the word in data_out was sampled low
//   parity_err   parity check failed for the word in data_out
//   overrun      sticky: a completed frame was dropped because the buffer was full
//   busy         receiver is inside a frame (not IDLE, not BREAK)
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int CNT_W = 4;
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STP_LAST = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state;
  logic [1:0]           sync_q;
  logic                 rxs;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_acc;
  logic                 pe_acc;
  logic                 start_clr;
  logic                 samp;
  logic                 complete;
  logic                 par_x;

  assign rxs       = sync_q[1];
  // >= rather than == so that shrinking baud_div mid-count wraps at once
  assign tick      = (div_cnt >= baud_div);
  assign start_clr = (state == S_IDLE) && !rxs;
  assign samp      = tick && (os_cnt == OS_LAST);
  assign complete  = (state == S_STOP) && samp && (bit_cnt == STP_LAST);
  assign par_x     = (^shreg) ^ rxs;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end

  always_ff @(posedge clk) begin
    if (rst || start_clr || tick) div_cnt <= '0;
    else                          div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      fe_acc     <= 1'b0;
      pe_acc     <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            os_cnt  <= '0;
            bit_cnt <= '0;
            fe_acc  <= 1'b0;
            pe_acc  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (os_cnt == OS_HALF) begin
              // Re-aligning the tick counter here puts every later sample
              // at the centre of its bit.
              os_cnt  <= '0;
              bit_cnt <= '0;
              if (rxs) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_DATA;
              end
            end else begin
              os_cnt <= os_cnt + OS_W'(1);
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              shreg  <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == DAT_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else begin
              os_cnt <= os_cnt + OS_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              pe_acc  <= (PARITY == 1) ? ~par_x : par_x;
              state   <= S_STOP;
            end else begin
              os_cnt <= os_cnt + OS_W'(1);
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              fe_acc <= fe_acc | ~rxs;
              if (bit_cnt == STP_LAST) begin
                // A line still low at the last stop sample is a break:
                // park until it returns high so no bogus frames start.
                state   <= rxs ? S_IDLE : S_BREAK;
                bit_cnt <= '0;
                busy    <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else begin
              os_cnt <= os_cnt + OS_W'(1);
            end
          end
        end
        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Output buffer: load on completion if empty or drained this cycle,
      // otherwise drop the frame and flag overrun.
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          frame_err  <= fe_acc | ~rxs;
          parity_err <= pe_acc;
          data_valid <= 1'b1;
          if (data_valid) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- directed vector bench for uart_rx_param.
// u0: defaults (8N1). u1: PARITY=2 (even). Separate serial lines.
module tb_uart_rx_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rxd0, rxd1;
  logic [15:0] baud_div;
  logic        data_ready;

  logic [7:0]  data_out0, data_out1;
  logic        dv0, dv1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

  uart_rx_param u0 (
    .clk(clk), .rst(rst), .rxd(rxd0), .baud_div(baud_div),
    .data_out(data_out0), .data_valid(dv0), .data_ready(data_ready),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(busy0)
  );

  uart_rx_param #(.PARITY(2)) u1 (
    .clk(clk), .rst(rst), .rxd(rxd1), .baud_div(baud_div),
    .data_out(data_out1), .data_valid(dv1), .data_ready(data_ready),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word capture: counts data_valid rising edges and high cycles per DUT.
  int         words [2];
  int         dvcyc [2];
  logic [7:0] cap_d [2];
  logic       cap_fe[2];
  logic       cap_pe[2];
  logic       dvq   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      words[i] = 0; dvcyc[i] = 0; cap_d[i] = '0;
      cap_fe[i] = 1'b0; cap_pe[i] = 1'b0; dvq[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (dv0) dvcyc[0]++;
    if (dv1) dvcyc[1]++;
    if (dv0 && !dvq[0]) begin
      words[0]++; cap_d[0] = data_out0; cap_fe[0] = fe0; cap_pe[0] = pe0;
    end
    if (dv1 && !dvq[1]) begin
      words[1]++; cap_d[1] = data_out1; cap_fe[1] = fe1; cap_pe[1] = pe1;
    end
    dvq[0] = dv0;
    dvq[1] = dv1;
  end

  task automatic drive_bit(input int sel, input logic b);
    int n;
    n = (int'(baud_div) + 1) * 16;
    if (sel == 1) rxd1 = b;
    else          rxd0 = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic stopb);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (has_par) drive_bit(sel, pbit);
    drive_bit(sel, stopb);
  endtask

  typedef struct {
    int          sel;
    logic [15:0] div;
    logic [7:0]  d;
    logic        has_par;
    logic        pbit;
    logic [7:0]  exp_d;
    logic        exp_pe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w0, c0, w1;

    vecs[0] = '{0, 16'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{0, 16'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{0, 16'd0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{0, 16'd2, 8'h96, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[4] = '{1, 16'd0, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1};
    vecs[5] = '{1, 16'd0, 8'h03, 1'b1, 1'b0, 8'h03, 1'b0};
    vecs[6] = '{1, 16'd0, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0};
    vecs[7] = '{1, 16'd0, 8'h07, 1'b1, 1'b0, 8'h07, 1'b1};

    rst = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1; baud_div = '0; data_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", {24'd0, data_out0}, 32'h0);
    chk("rst_valid",    {31'd0, dv0},   32'h0);
    chk("rst_frame",    {31'd0, fe0},   32'h0);
    chk("rst_parity",   {31'd0, pe0},   32'h0);
    chk("rst_overrun",  {31'd0, ov0},   32'h0);
    chk("rst_busy",     {31'd0, busy0}, 32'h0);
    chk("rst_busy_p",   {31'd0, busy1}, 32'h0);
    chk("rst_ovr_p",    {31'd0, ov1},   32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven frames
    foreach (vecs[k]) begin
      int s;
      s = vecs[k].sel;
      baud_div = vecs[k].div;
      w0 = words[s]; c0 = dvcyc[s];
      send_frame(s, vecs[k].d, vecs[k].has_par, vecs[k].pbit, 1'b1);
      drive_bit(s, 1'b1);
      drive_bit(s, 1'b1);
      chk($sformatf("v%0d_words", k), words[s] - w0, 1);
      chk($sformatf("v%0d_dvcyc", k), dvcyc[s] - c0, 1);
      chk($sformatf("v%0d_data", k), {24'd0, cap_d[s]}, {24'd0, vecs[k].exp_d});
      chk($sformatf("v%0d_ferr", k), {31'd0, cap_fe[s]}, 32'h0);
      chk($sformatf("v%0d_perr", k), {31'd0, cap_pe[s]}, {31'd0, vecs[k].exp_pe});
    end
    baud_div = '0;

    // Glitch shorter than half a bit is rejected
    w0 = words[0];
    rxd0 = 1'b0;
    repeat (4) @(negedge clk);
    rxd0 = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", {31'd0, busy0}, 32'h1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", {31'd0, busy0}, 32'h0);
    chk("glitch_nowords", words[0] - w0, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive_bit(0, 1'b1); drive_bit(0, 1'b1);
    chk("glitch_next_words", words[0] - w0, 1);
    chk("glitch_next_data", {24'd0, cap_d[0]}, 32'h3C);

    // Framing error followed by a long break
    w0 = words[0];
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("brk_words", words[0] - w0, 1);
    chk("brk_data", {24'd0, cap_d[0]}, 32'h55);
    chk("brk_ferr", {31'd0, cap_fe[0]}, 32'h1);
    repeat (20) drive_bit(0, 1'b0);
    chk("brk_busy_mid", {31'd0, busy0}, 32'h0);
    repeat (20) drive_bit(0, 1'b0);
    chk("brk_busy_end", {31'd0, busy0}, 32'h0);
    chk("brk_no_more", words[0] - w0, 1);
    drive_bit(0, 1'b1); drive_bit(0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive_bit(0, 1'b1); drive_bit(0, 1'b1);
    chk("brk_recover_words", words[0] - w0, 2);
    chk("brk_recover_data", {24'd0, cap_d[0]}, 32'h3C);
    chk("brk_recover_ferr", {31'd0, cap_fe[0]}, 32'h0);

    // Overrun with consumer stalled
    data_ready = 1'b0;
    w1 = words[0];
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    drive_bit(0, 1'b1);
    chk("ovr_first_no_ovr", {31'd0, ov0}, 32'h0);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    drive_bit(0, 1'b1); drive_bit(0, 1'b1);
    chk("ovr_words", words[0] - w1, 1);
    chk("ovr_valid", {31'd0, dv0}, 32'h1);
    chk("ovr_data", {24'd0, data_out0}, 32'h11);
    chk("ovr_flag", {31'd0, ov0}, 32'h1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("ovr_drain_valid", {31'd0, dv0}, 32'h0);
    chk("ovr_drain_flag",  {31'd0, ov0}, 32'h0);
    chk("ovr_drain_keep",  {24'd0, data_out0}, 32'h11);
    data_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset mid-DATA of 0xF0
    w0 = words[0];
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    chk("mid_busy", {31'd0, busy0}, 32'h1);
    rst = 1'b1; rxd0 = 1'b1;
    @(negedge clk);
    chk("mid_rst_data",  {24'd0, data_out0}, 32'h0);
    chk("mid_rst_valid", {31'd0, dv0}, 32'h0);
    chk("mid_rst_busy",  {31'd0, busy0}, 32'h0);
    chk("mid_rst_flags", {29'd0, fe0, pe0, ov0}, 32'h0);
    rst = 1'b0;
    drive_bit(0, 1'b1); drive_bit(0, 1'b1);
    chk("mid_no_partial", words[0] - w0, 0);
    send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
    drive_bit(0, 1'b1); drive_bit(0, 1'b1);
    chk("post_rst_words", words[0] - w0, 1);
    chk("post_rst_data", {24'd0, cap_d[0]}, 32'h0F);
    chk("post_rst_errs", {30'd0, cap_fe[0], cap_pe[0]}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, baud ticks per bit, even, legal 8..32.
REQ-003 SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bits checked, legal 1 or 2.
REQ-005 SHALL provide parameter DIV_W, default 16, width of baud_div.
REQ-006 SHALL use the port clk, input, 1, the system clock; all logic is on the rising edge.
REQ-007 SHALL use the port rst, input, 1, the reset, which is synchronous and active-high.
REQ-008 SHALL provide port rxd, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL provide port baud_div, input, DIV_W, clocks per baud tick minus 1.
REQ-010 SHALL provide port data_out, output, DATA_BITS, received word.
REQ-011 SHALL provide port data_valid, output, 1, data_out holds an unconsumed word.
REQ-012 SHALL provide port data_ready, input, 1, consumer accepts the word.
REQ-013 SHALL provide port frame_err, output, 1, framing error of the word in data_out.
REQ-014 SHALL provide port parity_err, output, 1, parity error of the word in data_out.
REQ-015 SHALL provide port overrun, output, 1, sticky flag: at least one frame was dropped.
REQ-016 SHALL provide port busy, output, 1, high in every state except IDLE and BREAK.

Function
REQ-017 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-018 SHALL run a baud counter div_cnt 0..baud_div; tick is high in cycles where div_cnt>=baud_div, and div_cnt then wraps to 0 (baud_div=0 gives a tick every clock).
REQ-019 SHALL clear div_cnt and the tick counter on the IDLE->START transition.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-021 IDLE: rxs==0 -> START.
REQ-022 START: sample rxs on tick OVERSAMPLE/2; if 1 -> IDLE (glitch reject, no output); if 0 -> DATA, clearing tick and bit counters.
REQ-023 DATA: sample on every OVERSAMPLE-th tick; shift right with rxs entering the MSB (LSB first); after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-024 PARITY: sample one bit; parity_err_next=1 when XOR(data, bit) is 0 for odd mode or 1 for even mode.
REQ-025 STOP: sample STOP_BITS bits; any 0 sets frame_err_next; after the last stop sample -> IDLE if that sample is 1, else BREAK.
REQ-026 BREAK: wait for rxs==1, then -> IDLE; no frame is started while in BREAK.
REQ-027 SHALL complete a frame on the clock edge that takes the last stop sample.
REQ-028 On frame completion with data_valid==0, or with data_valid&&data_ready in the same cycle: load data_out/frame_err/parity_err and set data_valid=1 at that edge.
REQ-029 On frame completion with data_valid==1 and data_ready==0: keep data_out and flags, drop the new frame, and set overrun=1.
REQ-030 data_valid&&data_ready without completion: clear data_valid and overrun next edge; keep data_out and flags until the next load.
REQ-031 frame_err and parity_err SHALL be loaded only together with data_out, including on frames with errors.
REQ-032 A change of baud_div mid-frame SHALL take effect at the next div_cnt compare without lockup.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, synchronizer flops=1, div_cnt=0, tick and bit counters=0, shift register=0.
REQ-034 On the same reset: data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
REQ-035 rst SHALL override any frame in progress; no partial word is delivered.

Verification
REQ-036 Defaults, baud_div=0 (16 clk/bit), data_ready=1: send 0xA5 8N1 -> data_out=0xA5, data_valid high 1 cycle, frame_err=0, parity_err=0.
REQ-037 rxd low for 4 clocks, then high -> no data_valid, busy returns to 0, next frame 0x3C received correctly.
REQ-038 Send 0x55 with stop bit=0, then hold rxd low for 40 bit times -> one word 0x55 with frame_err=1, no further words, and state=BREAK until rxd goes high.
REQ-039 PARITY=2: send 0x03 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
REQ-040 data_ready=0: send 0x11 then 0x22 -> data_out=0x11, overrun=1; pulse data_ready -> data_valid=0 and overrun=0 next cycle.
REQ-041 Assert rst mid-DATA of frame 0xF0 -> all outputs 0; next frame 0x0F gives data_out=0x0F with no errors.
